// File: rtl/irq_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter_pkg
// Description : Shared state encoding, register map and helpers for the
//               interrupt arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_arbiter_pkg;

    localparam int c_n_irq_default = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_st_idle    = 2'd0;
    localparam state_t c_st_req     = 2'd1;
    localparam state_t c_st_service = 2'd2;

    localparam logic [1:0] c_addr_enable  = 2'd0;
    localparam logic [1:0] c_addr_pending = 2'd1;
    localparam logic [1:0] c_addr_irq_id  = 2'd2;
    localparam logic [1:0] c_addr_state   = 2'd3;

    // Fixed priority: the lowest set index wins; returns 0 for an empty vector.
    function automatic logic [2:0] lowest_set(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync_edge
// Description : One interrupt line: synchronizer chain, history flop and
//               rising-edge detect.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic nrst,
    input  logic irq_async,
    output logic rise
);

    localparam int c_cnt_w = $clog2(SYNC_STAGES + 2);
    localparam logic [c_cnt_w-1:0] c_warm_done = c_cnt_w'(SYNC_STAGES + 1);
    localparam logic [c_cnt_w-1:0] c_one       = c_cnt_w'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic [c_cnt_w-1:0]     r_warm;

    // The warm-up count blocks a rise until history holds a post-reset sample,
    // so a line that is already high when reset releases never looks like an edge.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_sync <= '0;
            r_hist <= 1'b0;
            r_warm <= '0;
        end else begin
            r_sync[0] <= irq_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_hist <= r_sync[SYNC_STAGES-1];
            if (r_warm != c_warm_done) begin
                r_warm <= r_warm + c_one;
            end
        end
    end

    assign rise = r_sync[SYNC_STAGES-1] & ~r_hist & (r_warm == c_warm_done);

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : irq_arbiter
// Description : Edge-triggered interrupt arbiter with pending/enable registers
//               and a fixed-priority IDLE/REQ/SERVICE handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_arbiter
    import irq_arbiter_pkg::*;
#(
    parameter int N_IRQ       = c_n_irq_default,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             isr_running,
    input  logic             sel_isr,
    input  logic             wr_en,
    input  logic [1:0]       wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [1:0]       rd_addr,
    output logic [7:0]       rd_data,
    output logic             int_sig,
    output logic [2:0]       irq_id
);

    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_req;
    logic [N_IRQ-1:0] w_pending_nxt;
    logic [7:0]       w_req_ext;
    logic [7:0]       w_enable_ext;
    logic [7:0]       w_pending_ext;
    logic [2:0]       w_grant_id;
    logic             w_grant_clr;
    logic             w_w1c;
    logic             w_enable_wr;

    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_enable;
    state_t           r_state;
    logic             r_int_sig;
    logic [2:0]       r_irq_id;
    logic             r_isr_prev;

    generate
        for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_line
            irq_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES)
            ) u_sync_edge (
                .clk       (clk),
                .nrst      (nrst),
                .irq_async (irq_in[gi]),
                .rise      (w_rise[gi])
            );
        end
    endgenerate

    assign w_req       = r_pending & r_enable;
    assign w_grant_clr = (r_state == c_st_req) & sel_isr;
    assign w_w1c       = wr_en & (wr_addr == c_addr_pending);
    assign w_enable_wr = wr_en & (wr_addr == c_addr_enable);

    always_comb begin
        w_req_ext                = '0;
        w_req_ext[N_IRQ-1:0]     = w_req;
        w_enable_ext             = '0;
        w_enable_ext[N_IRQ-1:0]  = r_enable;
        w_pending_ext            = '0;
        w_pending_ext[N_IRQ-1:0] = r_pending;
    end

    assign w_grant_id = lowest_set(w_req_ext);

    // Clears are applied first so that a same-cycle rise always survives.
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < N_IRQ; i++) begin
            if (w_grant_clr && (r_irq_id == 3'(i))) begin
                w_pending_nxt[i] = 1'b0;
            end
        end
        if (w_w1c) begin
            w_pending_nxt = w_pending_nxt & ~wr_data[N_IRQ-1:0];
        end
        w_pending_nxt = w_pending_nxt | w_rise;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_pending  <= '0;
            r_enable   <= '1;
            r_isr_prev <= 1'b0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_isr_prev <= isr_running;
            if (w_enable_wr) begin
                r_enable <= wr_data[N_IRQ-1:0];
            end
        end
    end

    // Once in REQ the grant is committed: masking or clearing the line cannot retract it.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state   <= c_st_idle;
            r_int_sig <= 1'b0;
            r_irq_id  <= 3'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (|w_req) begin
                        r_irq_id  <= w_grant_id;
                        r_int_sig <= 1'b1;
                        r_state   <= c_st_req;
                    end
                end
                c_st_req: begin
                    if (sel_isr) begin
                        r_int_sig <= 1'b0;
                        r_state   <= c_st_service;
                    end
                end
                c_st_service: begin
                    r_int_sig <= 1'b0;
                    if (r_isr_prev && !isr_running) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_int_sig <= 1'b0;
                    r_state   <= c_st_idle;
                end
            endcase
        end
    end

    always_comb begin
        case (rd_addr)
            c_addr_enable:  rd_data = w_enable_ext;
            c_addr_pending: rd_data = w_pending_ext;
            c_addr_irq_id:  rd_data = {5'b0, r_irq_id};
            default:        rd_data = {6'b0, r_state};
        endcase
    end

    assign int_sig = r_int_sig;
    assign irq_id  = r_irq_id;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_arbiter
// Description : Self-checking bench for irq_arbiter against a sample-history
//               reference model, with directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_irq_arbiter;

    localparam int N    = 8;
    localparam int SYNC = 2;

    logic       clk         = 1'b0;
    logic       nrst        = 1'b0;
    logic [7:0] irq_in      = '0;
    logic       isr_running = 1'b0;
    logic       sel_isr     = 1'b0;
    logic       wr_en       = 1'b0;
    logic [1:0] wr_addr     = '0;
    logic [7:0] wr_data     = '0;
    logic [1:0] rd_addr     = '0;
    logic [7:0] rd_data;
    logic       int_sig;
    logic [2:0] irq_id;

    irq_arbiter #(
        .N_IRQ       (N),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .irq_in      (irq_in),
        .isr_running (isr_running),
        .sel_isr     (sel_isr),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .int_sig     (int_sig),
        .irq_id      (irq_id)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: raw samples per edge with a validity flag (cleared by reset).
    typedef enum int {M_IDLE = 0, M_REQ = 1, M_SERVICE = 2} mstate_t;
    logic [7:0] m_samp [SYNC+1];
    bit         m_vld  [SYNC+1];
    logic [7:0] m_pend = '0;
    logic [7:0] m_en   = 8'hFF;
    mstate_t    m_st   = M_IDLE;
    bit         m_int  = 1'b0;
    int         m_id   = 0;
    bit         m_isr_prev = 1'b0;
    logic [7:0] flip;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] m_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'b0, m_en};
            2'd1:    return {24'b0, m_pend};
            2'd2:    return 32'(m_id);
            default: return 32'(int'(m_st));
        endcase
    endfunction

    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] req;
        logic [7:0] nxt;
        if (!nrst) begin
            m_pend = '0; m_en = 8'hFF; m_st = M_IDLE; m_int = 1'b0; m_id = 0;
            m_isr_prev = 1'b0;
            for (int k = 0; k <= SYNC; k++) m_vld[k] = 1'b0;
            return;
        end
        // A line rises when the sample seen SYNC edges ago is high and the one before was low.
        rise = (m_vld[SYNC-1] && m_vld[SYNC]) ? (m_samp[SYNC-1] & ~m_samp[SYNC]) : 8'h00;
        for (int k = SYNC; k > 0; k--) begin
            m_samp[k] = m_samp[k-1];
            m_vld[k]  = m_vld[k-1];
        end
        m_samp[0] = irq_in;
        m_vld[0]  = 1'b1;
        nxt = m_pend;
        req = m_pend & m_en;
        case (m_st)
            M_IDLE: if (req != 8'h00) begin
                for (int i = N-1; i >= 0; i--) if (req[i]) m_id = i;
                m_int = 1'b1;
                m_st  = M_REQ;
            end
            M_REQ: if (sel_isr) begin
                nxt[m_id] = 1'b0;
                m_int = 1'b0;
                m_st  = M_SERVICE;
            end
            default: if (m_isr_prev && !isr_running) m_st = M_IDLE;
        endcase
        if (wr_en && wr_addr == 2'd1) nxt = nxt & ~wr_data;
        if (wr_en && wr_addr == 2'd0) m_en = wr_data;
        m_pend = nxt | rise;
        m_isr_prev = isr_running;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        chk("int_sig", {31'b0, int_sig}, {31'b0, m_int});
        chk("irq_id", {29'b0, irq_id}, 32'(m_id));
        rd_addr = 2'($urandom_range(0, 3));
        #1;
        chk("rd_data", {24'b0, rd_data}, m_rd(rd_addr));
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [7:0] e, input string name);
        rd_addr = a;
        #1;
        chk(name, {24'b0, rd_data}, {24'b0, e});
    endtask

    task automatic service();
        sel_isr = 1'b1;
        cycle();
        sel_isr = 1'b0;
        isr_running = 1'b1;
        cycle();
        isr_running = 1'b0;
        cycle();
    endtask

    initial begin
        for (int k = 0; k <= SYNC; k++) begin
            m_samp[k] = '0;
            m_vld[k]  = 1'b0;
        end
        nrst = 1'b0;
        cycle();
        cycle();
        expect_rd(2'd0, 8'hFF, "reset_enable");
        expect_rd(2'd1, 8'h00, "reset_pending");
        expect_rd(2'd3, 8'h00, "reset_state");
        nrst = 1'b1;
        repeat (6) cycle();

        // Single pulse on line 3
        irq_in[3] = 1'b1; cycle(); irq_in[3] = 1'b0;
        cycle(); cycle();
        expect_rd(2'd1, 8'h08, "p3_pending");
        chk("p3_int_early", {31'b0, int_sig}, 32'd0);
        cycle();
        chk("p3_int", {31'b0, int_sig}, 32'd1);
        chk("p3_id", {29'b0, irq_id}, 32'd3);
        sel_isr = 1'b1; cycle(); sel_isr = 1'b0;
        chk("p3_int_clr", {31'b0, int_sig}, 32'd0);
        expect_rd(2'd1, 8'h00, "p3_pending_clr");
        isr_running = 1'b1; cycle(); isr_running = 1'b0; cycle();
        expect_rd(2'd3, 8'h00, "p3_back_idle");

        // Simultaneous rises on lines 5 and 2
        irq_in = 8'h24; cycle(); irq_in = 8'h00;
        cycle(); cycle();
        expect_rd(2'd1, 8'h24, "pri_pending");
        cycle();
        chk("pri_id_first", {29'b0, irq_id}, 32'd2);
        sel_isr = 1'b1; cycle(); sel_isr = 1'b0;
        isr_running = 1'b1; cycle(); isr_running = 1'b0; cycle();
        cycle();
        chk("pri_int_second", {31'b0, int_sig}, 32'd1);
        chk("pri_id_second", {29'b0, irq_id}, 32'd5);
        service();

        // Masked line becomes visible once enabled
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'hFE; cycle(); wr_en = 1'b0;
        irq_in[0] = 1'b1; cycle(); irq_in[0] = 1'b0;
        repeat (4) cycle();
        expect_rd(2'd1, 8'h01, "mask_pending");
        chk("mask_int", {31'b0, int_sig}, 32'd0);
        wr_en = 1'b1; wr_data = 8'hFF; cycle(); wr_en = 1'b0;
        cycle();
        chk("unmask_int", {31'b0, int_sig}, 32'd1);
        chk("unmask_id", {29'b0, irq_id}, 32'd0);
        service();

        // Edge during SERVICE waits for isr_running to fall
        irq_in[4] = 1'b1; cycle(); irq_in[4] = 1'b0;
        repeat (3) cycle();
        sel_isr = 1'b1; cycle(); sel_isr = 1'b0;
        isr_running = 1'b1; irq_in[1] = 1'b1; cycle(); irq_in[1] = 1'b0;
        repeat (4) cycle();
        chk("nest_int_held", {31'b0, int_sig}, 32'd0);
        expect_rd(2'd1, 8'h02, "nest_pending");
        isr_running = 1'b0; cycle(); cycle();
        chk("nest_int", {31'b0, int_sig}, 32'd1);
        chk("nest_id", {29'b0, irq_id}, 32'd1);
        service();

        // W1C in the same cycle as a rise keeps the bit
        irq_in[2] = 1'b1; cycle(); irq_in[2] = 1'b0; cycle();
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h04; cycle(); wr_en = 1'b0;
        expect_rd(2'd1, 8'h04, "w1c_vs_rise");
        cycle();
        service();

        // Reset while in REQ with line 6 held high
        irq_in[6] = 1'b1;
        repeat (4) cycle();
        chk("rst_pre_id", {29'b0, irq_id}, 32'd6);
        nrst = 1'b0; cycle(); nrst = 1'b1;
        chk("rst_int", {31'b0, int_sig}, 32'd0);
        expect_rd(2'd3, 8'h00, "rst_state");
        expect_rd(2'd1, 8'h00, "rst_pending");
        repeat (8) cycle();
        chk("rst_held_no_req", {31'b0, int_sig}, 32'd0);
        irq_in[6] = 1'b0; repeat (2) cycle();
        irq_in[6] = 1'b1; repeat (4) cycle();
        chk("rst_rearm_int", {31'b0, int_sig}, 32'd1);
        chk("rst_rearm_id", {29'b0, irq_id}, 32'd6);
        irq_in = 8'h00;
        service();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            flip = '0;
            for (int b = 0; b < 8; b++) if ($urandom_range(0, 11) == 0) flip[b] = 1'b1;
            irq_in  = irq_in ^ flip;
            sel_isr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) isr_running = ~isr_running;
            wr_en   = ($urandom_range(0, 15) == 0);
            wr_addr = 2'($urandom_range(0, 3));
            wr_data = 8'($urandom);
            if (wr_en && wr_addr == 2'd0 && $urandom_range(0, 1) == 1) wr_data = 8'hFF;
            nrst = ($urandom_range(0, 499) != 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_arbiter.md
IRQ_ARBITER -- requirements
Module: irq_arbiter

Interface
REQ-001 SHALL have parameter N_IRQ, default 8, number of external interrupt lines (2..8).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth per line.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port nrst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port irq_in  input  N_IRQ  asynchronous interrupt lines; a rising edge requests service.
REQ-006 SHALL have port isr_running  input  1  ISR-running flag from the interrupt controller.
REQ-007 SHALL have port sel_isr  input  1  ISR-entry flag from the interrupt controller.
REQ-008 SHALL have port wr_en  input  1  register write strobe.
REQ-009 SHALL have port wr_addr  input  2  write register select.
REQ-010 SHALL have port wr_data  input  8  write data.
REQ-011 SHALL have port rd_addr  input  2  read register select.
REQ-012 SHALL have port rd_data  output  8  combinational read data.
REQ-013 SHALL have port int_sig  output  1  registered request to the interrupt controller.
REQ-014 SHALL have port irq_id  output  3  registered index of the granted line.

Function
REQ-015 Each line SHALL pass through SYNC_STAGES flops plus one history flop; rise = synced & ~history.
REQ-016 pending[i] SHALL be set on rise[i], regardless of enable[i].
REQ-017 With SYNC_STAGES=2, irq_in sampled high at edge k SHALL set pending at edge k+2; int_sig SHALL go high at edge k+3 if the FSM is IDLE and the line is enabled.
REQ-018 Register map: addr 0 = enable (RW), addr 1 = pending (read; write-1-to-clear), addr 2 = {5'b0, irq_id} (RO), addr 3 = {6'b0, state} (RO); unused bits read 0; writes to addr 2/3 ignored.
REQ-019 FSM states SHALL be IDLE, REQ, SERVICE.
REQ-020 IDLE: if (pending & enable) != 0, latch the lowest set index into irq_id, set int_sig, go to REQ; else stay.
REQ-021 REQ: int_sig held high; when sel_isr=1, clear pending[irq_id], clear int_sig, go to SERVICE.
REQ-022 SERVICE: int_sig=0; on isr_running 1->0 (registered previous value), go to IDLE.
REQ-023 A grant committed in REQ SHALL NOT be withdrawn by a mask write or W1C of that line.
REQ-024 Set beats clear: a rise in the same cycle as a grant-clear or W1C leaves pending set.
REQ-025 Edges arriving in REQ/SERVICE SHALL only set pending (no nesting); serviced on return to IDLE.
REQ-026 Repeated edges on an already-pending line SHALL coalesce into one request.
REQ-027 irq_id SHALL hold its value from grant until the next grant.

Reset
REQ-028 On nrst=0 at a clock edge: state=IDLE, int_sig=0, irq_id=0, pending=0, enable=all ones, synchronizer and history flops=0, registered isr_running=0.
REQ-029 Reset mid-REQ or mid-SERVICE SHALL drop the request; edges during reset are lost; lines already high at release SHALL NOT produce a rise.

Structure
REQ-030 Shared package SHALL hold the state encoding (IDLE=0, REQ=1, SERVICE=2), register address constants, and the N_IRQ default.
REQ-031 A sub-module irq_sync_edge (one line: synchronizer, history flop, rise output) SHALL be instantiated N_IRQ times.

Verification
REQ-032 Pulse irq_in[3] at edge 10, enable=0xFF -> pending=0x08 at edge 12, int_sig=1 and irq_id=3 at edge 13; sel_isr=1 -> int_sig=0, pending=0x00 next edge.
REQ-033 Rise irq_in[5] and irq_in[2] in the same cycle -> irq_id=2 granted first; after isr_running 1->0, irq_id=5 granted.
REQ-034 enable=0xFE, pulse irq_in[0] -> pending=0x01, int_sig stays 0; write enable=0xFF -> int_sig=1, irq_id=0 next edge.
REQ-035 Pulse irq_in[1] while in SERVICE for line 4 -> int_sig stays 0 until isr_running falls, then int_sig=1, irq_id=1.
REQ-036 W1C addr 1 data 0x04 in the same cycle as rise[2] -> pending[2] stays 1.
REQ-037 nrst=0 for one edge while in REQ with irq_in[6] held high -> int_sig=0, state=IDLE, pending=0; no request after release until irq_in[6] falls and rises again.
